// File: rtl/regfile_wb_pkg.sv
// Shared widths and the queued write-back entry type for the register file
// write-back unit.
package regfile_wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of packed write-back entries; the whole entry array and the
// pointers are exposed so the owner can search queued writes.
module wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 37,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] entries [DEPTH],
  output logic [PTR_W-1:0] head_ptr,
  output logic [PTR_W-1:0] tail_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      // DEPTH is a power of two, so plain increment wraps the pointers.
      if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only ever observed while count
  // says it is valid, so a reset on the array would only cost area.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end

  assign entries   = mem;
  assign head_data = mem[head_ptr];

endmodule

// File: rtl/regfile_writeback_unit.sv
// Write-side initiator for the MIPS register file: arbitrates ALU/load results
// into an in-order queue, drains it to the write port and offers bypass lookup.
module regfile_writeback_unit
  import regfile_wb_pkg::REG_ZERO;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  input  logic                       wb_stall,
  output logic [ADDR_W-1:0]          waddr,
  output logic [DATA_W-1:0]          wdata,
  output logic                       wren,
  input  logic [ADDR_W-1:0]          fwd_raddr0,
  input  logic [ADDR_W-1:0]          fwd_raddr1,
  output logic                       fwd_hit0,
  output logic                       fwd_hit1,
  output logic [DATA_W-1:0]          fwd_data0,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int WIDTH = ADDR_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic             mem_take;
  logic             alu_take;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_dat;
  logic             push;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] idx;

  // Loads win over ALU results; readiness depends only on full, never on a pop.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_take  = mem_valid && mem_ready;
  assign alu_take  = alu_valid && alu_ready;

  assign push_addr = mem_take ? mem_addr : alu_addr;
  assign push_dat  = mem_take ? mem_data : alu_data;
  // Writes to r0 complete the handshake but are never queued.
  assign push      = (mem_take || alu_take) && (push_addr != ZERO_ADDR);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_addr, push_dat}),
    .pop       (wren),
    .head_data (head_data),
    .entries   (entries),
    .head_ptr  (head_ptr),
    .tail_ptr  (tail_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign pending_cnt = count;
  assign wren        = !empty && !wb_stall;
  assign waddr       = empty ? '0 : head_data[DATA_W +: ADDR_W];
  assign wdata       = empty ? '0 : head_data[DATA_W-1:0];

  // Youngest-first scan from tail-1 back to head; first match wins.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a value held and infer a latch.
  always_comb begin
    fwd_hit0  = 1'b0;
    fwd_hit1  = 1'b0;
    fwd_data0 = '0;
    fwd_data1 = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail_ptr - PTR_W'(i + 1);
      if (CNT_W'(i) < count) begin
        if (!fwd_hit0 && fwd_raddr0 != ZERO_ADDR &&
            entries[idx][DATA_W +: ADDR_W] == fwd_raddr0) begin
          fwd_hit0  = 1'b1;
          fwd_data0 = entries[idx][DATA_W-1:0];
        end
        if (!fwd_hit1 && fwd_raddr1 != ZERO_ADDR &&
            entries[idx][DATA_W +: ADDR_W] == fwd_raddr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = entries[idx][DATA_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench: directed scenarios plus random traffic compared every
// cycle against a queue-based model of the write-back unit.
module tb_regfile_writeback_unit;
  import regfile_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, mem_valid, wb_stall;
  logic [ADDR_W-1:0] alu_addr, mem_addr, fwd_raddr0, fwd_raddr1;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready, wren, fwd_hit0, fwd_hit1, full, empty;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata, fwd_data0, fwd_data1;
  logic [CNT_W-1:0]  pending_cnt;

  always #5 clk = ~clk;

  regfile_writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .waddr(waddr), .wdata(wdata), .wren(wren),
    .fwd_raddr0(fwd_raddr0), .fwd_raddr1(fwd_raddr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1), .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
    .pending_cnt(pending_cnt), .full(full), .empty(empty)
  );

  // Register file fed by the write port, read back to confirm committed values.
  logic [DATA_W-1:0] rf [32];
  always @(posedge clk) if (wren) rf[waddr] <= wdata;

  wb_entry_t model_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W:0] model_fwd(input logic [ADDR_W-1:0] a);
    if (a == REG_ZERO) return '0;
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i].addr == a) return {1'b1, model_q[i].data};
    return '0;
  endfunction

  // Called just after a negedge with inputs driven: compare, then advance the model.
  task automatic step();
    logic exp_full, exp_empty, exp_wren, mem_acc, alu_acc;
    logic [DATA_W:0] f0, f1;
    wb_entry_t e;
    #1;
    exp_full  = (model_q.size() == DEPTH);
    exp_empty = (model_q.size() == 0);
    exp_wren  = !exp_empty && !wb_stall;
    f0 = model_fwd(fwd_raddr0);
    f1 = model_fwd(fwd_raddr1);
    check("mem_ready", mem_ready, !exp_full);
    check("alu_ready", alu_ready, !exp_full && !mem_valid);
    check("wren", wren, exp_wren);
    check("waddr", waddr, exp_empty ? 0 : model_q[0].addr);
    check("wdata", wdata, exp_empty ? 0 : model_q[0].data);
    check("pending_cnt", pending_cnt, model_q.size());
    check("full", full, exp_full);
    check("empty", empty, exp_empty);
    check("fwd_hit0", fwd_hit0, f0[DATA_W]);
    check("fwd_data0", fwd_data0, f0[DATA_W-1:0]);
    check("fwd_hit1", fwd_hit1, f1[DATA_W]);
    check("fwd_data1", fwd_data1, f1[DATA_W-1:0]);
    mem_acc = mem_valid && !exp_full;
    alu_acc = alu_valid && !exp_full && !mem_valid;
    @(posedge clk);
    if (exp_wren) e = model_q.pop_front();
    if (mem_acc && mem_addr != REG_ZERO)      model_q.push_back('{addr: mem_addr, data: mem_data});
    else if (alu_acc && alu_addr != REG_ZERO) model_q.push_back('{addr: alu_addr, data: alu_data});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; wb_stall = 0;
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    fwd_raddr0 = '0; fwd_raddr1 = '0;
  endtask

  task automatic alu_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    alu_valid = 1; alu_addr = a; alu_data = d;
    step();
    alu_valid = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    step();
    check("reset_alu_ready", alu_ready, 1);

    // Single ALU write reaches the register file.
    alu_push(5'd3, 32'h11);
    step();
    step();
    check("rf_r3", rf[3], 32'h11);

    // Simultaneous offers: load wins, ALU follows next cycle.
    mem_valid = 1; mem_addr = 5'd4; mem_data = 32'hAA;
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hBB;
    step();
    mem_valid = 0;
    step();
    alu_valid = 0;
    repeat (3) step();
    check("rf_r4", rf[4], 32'hAA);
    check("rf_r5", rf[5], 32'hBB);

    // Fill under stall, try to push while full, then drain in order.
    wb_stall = 1;
    for (int i = 1; i <= 4; i++) alu_push(ADDR_W'(i), 32'h100 + 32'(i));
    #1;
    check("stall_full", full, 1);
    check("stall_cnt", pending_cnt, 4);
    @(negedge clk);
    mem_valid = 1; mem_addr = 5'd9; mem_data = 32'hDEAD;
    step();
    mem_valid = 0; wb_stall = 0;
    repeat (5) step();
    check("drain_empty", empty, 1);
    check("rf_r4_drain", rf[4], 32'h104);

    // Youngest match wins; r0 never hits.
    wb_stall = 1;
    alu_push(5'd7, 32'd1);
    alu_push(5'd7, 32'd2);
    fwd_raddr0 = 5'd7; fwd_raddr1 = 5'd0;
    #1;
    check("fwd_young_hit", fwd_hit0, 1);
    check("fwd_young_data", fwd_data0, 2);
    check("fwd_r0_hit", fwd_hit1, 0);
    @(negedge clk);
    wb_stall = 0;
    repeat (3) step();

    // Write to r0 completes but is dropped.
    alu_push(5'd0, 32'hFFFF);
    check("r0_cnt", pending_cnt, 0);
    step();

    // Asynchronous reset with queued entries; nothing stale afterwards.
    wb_stall = 1;
    for (int i = 0; i < 3; i++) alu_push(ADDR_W'(10 + i), 32'h200 + 32'(i));
    #2 rst = 1;
    #1;
    check("rst_wren", wren, 0);
    check("rst_cnt", pending_cnt, 0);
    check("rst_empty", empty, 1);
    check("rst_waddr", waddr, 0);
    check("rst_mem_ready", mem_ready, 1);
    model_q.delete();
    @(negedge clk);
    rst = 0; wb_stall = 0;
    repeat (3) step();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      mem_valid  = ($urandom_range(3) == 0);
      alu_valid  = ($urandom_range(1) == 0);
      wb_stall   = ($urandom_range(9) < 4);
      mem_addr   = ADDR_W'($urandom_range(7));
      alu_addr   = ADDR_W'($urandom_range(7));
      mem_data   = $urandom;
      alu_data   = $urandom;
      fwd_raddr0 = ADDR_W'($urandom_range(7));
      fwd_raddr1 = ADDR_W'($urandom_range(7));
      step();
    end
    idle_inputs();
    repeat (DEPTH + 1) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_unit.md
# regfile_writeback_unit

Write-side initiator for the 32x32 two-read/one-write MIPS register file. Accepts results from the ALU and memory pipes with valid/ready handshakes and queues them in order. Drains one entry per cycle onto the register file's `waddr`/`wdata`/`wren` write port. Provides bypass lookup so read operands can see queued, not-yet-committed writes.

## Interface
- `DEPTH`, 4, number of queue entries (power of two, ≥2)
- `DATA_W`, 32, result width
- `ADDR_W`, 5, register address width
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result offered
- `alu_addr`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`
- `mem_valid`  in  1  load result offered
- `mem_addr`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load result
- `mem_ready`  out  1  load accepted when high with `mem_valid`
- `wb_stall`  in  1  hold the write port (no drain this cycle)
- `waddr`  out  ADDR_W  register file write address
- `wdata`  out  DATA_W  register file write data
- `wren`  out  1  register file write enable
- `fwd_raddr0`, `fwd_raddr1`  in  ADDR_W  read addresses to check against the queue
- `fwd_hit0`, `fwd_hit1`  out  1  a queued entry targets that address
- `fwd_data0`, `fwd_data1`  out  DATA_W  data of the youngest matching entry
- `pending_cnt`  out  $clog2(DEPTH+1)  queued entries
- `full`, `empty`  out  1  queue status

## Operation
- Circular FIFO of {addr, data}. Write order equals acceptance order, which guarantees WAW correctness.
- Enqueue at most one entry per cycle, with fixed priority mem > alu.
  - `mem_ready = !full`.
  - `alu_ready = !full && !mem_valid`.
- Accepted writes to register 0 are discarded: handshake completes, nothing is enqueued, count is unchanged.
- Drain: `wren = !empty && !wb_stall`. `waddr`/`wdata` come combinationally from the head entry.
  - The head pops on each edge where `wren` is high.
  - `waddr`/`wdata` are 0 when empty.
- Simultaneous push and pop: count is unchanged, both pointers advance.
  - `ready` depends only on `full` (no pass-through); a full queue rejects even when popping.
- Pointers wrap modulo `DEPTH`. `full` means count == DEPTH; `empty` means count == 0.
- Bypass:
  - `fwd_hitN` = any valid entry with addr == `fwd_raddrN` and `fwd_raddrN` != 0.
  - `fwd_dataN` = youngest such entry; 0 when there is no hit.
  - The head entry counts as queued until it pops.
  - Entries being accepted this cycle are not visible.
- Reset (asynchronous, any time): pointers and count go to 0 and all queued entries are dropped.
  - After reset: `wren`=0, `waddr`/`wdata`=0, `empty`=1, `full`=0, `pending_cnt`=0, `fwd_hit*`=0.
  - Ready outputs follow `full`=0: `mem_ready`=1; `alu_ready`=`!mem_valid`.

## Timing
- Accept at edge k → `wren` high in cycle k..k+1 (if not stalled) → register file written at edge k+1. Minimum latency is 1 cycle.
- Throughput: 1 write per cycle sustained. With no stall, the queue never exceeds 1 entry.
- `wb_stall` high for n cycles delays the drain by n cycles. Sources stall via ready after DEPTH accepts.
- Bypass outputs are combinational from current queue state and `fwd_raddr*`, with no added latency.

## Structure
- Package `regfile_wb_pkg`:
  - constants `ADDR_W`, `DATA_W`, `REG_ZERO` = 5'd0
  - struct `wb_entry_t` {addr, data}
- Sub-module `wb_fifo`: circular buffer with push/pop, count, full/empty, and the entry array exposed for the bypass search.
- Top level holds the arbitration, zero-register drop, drain logic and youngest-match search. The search scans from tail-1 back to head.

## Test plan
- Reset, then ALU writes (r3, 0x11) → `wren`=1, `waddr`=3, `wdata`=0x11 next cycle; the register file reads r3 = 0x11 afterwards.
- Same cycle `mem_valid` (r4, 0xAA) and `alu_valid` (r5, 0xBB) → mem accepted, `alu_ready`=0; ALU accepted the following cycle; writes are committed r4 then r5.
- `wb_stall`=1 and 4 accepts (r1..r4) → `full`=1, `pending_cnt`=4, both ready low. Release stall → 4 consecutive `wren` cycles in order, then `empty`=1.
- Stall, enqueue (r7, 1) then (r7, 2), set `fwd_raddr0`=7 → `fwd_hit0`=1, `fwd_data0`=2. With `fwd_raddr1`=0 → `fwd_hit1`=0.
- ALU write to r0 with data 0xFFFF → `alu_ready`=1, `pending_cnt` stays 0, `wren` never asserts.
- Stall with 3 entries, assert `rst` mid-cycle → outputs return to reset values immediately. After release, no stale writes are issued.
